// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Time-multiplexed hex driver for common-anode multi-digit seven-segment
//   displays. Scans one digit per REFRESH_DIV clocks, decodes nibbles to hex
//   glyphs, drives per-digit decimal points, optionally blanks leading zeros,
//   and double-buffers the value so updates only land on a frame boundary.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   value      4*NUM_DIGITS hex value, nibble i -> digit i (digit 0 rightmost)
//   dp_in      per-digit decimal point request, active-high
//   load       one-cycle strobe capturing value/dp_in into the shadow buffer
//   en         display enable; 0 blanks anodes, segments and dp
//   blank_lz   leading-zero blanking enable
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   an         anode selects, active-low, one-hot-zero
//   frame_tick one-cycle pulse after the scan wraps to digit 0
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    en,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  logic                    wrap, last_digit, boundary;
  logic [3:0]              nib_sel;
  logic                    dp_sel, lz_sel;
  logic [NUM_DIGITS-1:0]   zero_from;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Divider, digit index and double-buffer control
  always_comb begin
    wrap       = (div_q == DW'(REFRESH_DIV - 1));
    last_digit = (idx_q == IW'(NUM_DIGITS - 1));
    boundary   = wrap && last_digit;

    div_d = wrap ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (wrap) idx_d = last_digit ? '0 : idx_q + IW'(1);

    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    tick_d       = boundary;

    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    // A load landing on the boundary itself bypasses the shadow so it is
    // shown in the frame that starts now rather than one frame later.
    if (boundary) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
        pending_d  = 1'b0;
      end
    end
  end

  // Digit selection, leading-zero detection and output decode
  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    zero_from = '0;
    an_d      = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      // zero_from[i]: nibbles i..NUM_DIGITS-1 are all zero
      zero_from[i] = ((disp_val_q >> (4 * i)) == '0);
      an_d[i]      = !(idx_q == IW'(i));
      if (idx_q == IW'(i)) begin
        nib_sel = disp_val_q[4*i +: 4];
        dp_sel  = disp_dp_q[i];
        lz_sel  = (i != 0) && zero_from[i];
      end
    end

    seg_d = (blank_lz && lz_sel) ? 7'h7F : glyph(nib_sel);
    dp_d  = !dp_sel;

    if (!en) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Each frame is 16 output samples; sample s (1..16) after a frame_tick shows
// digit (s-1)/4, and sample 16 carries the next frame_tick.
module tb_sevenseg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        en;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  sevenseg_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .en        (en),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    string      name;
    int         sample;
  } exp_t;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic            blank;
    logic [3:0][6:0] seg;   // {d3,d2,d1,d0}
    logic [3:0]      dpn;   // active-low dp {d3..d0}
  } vec_t;

  exp_t sb[$];
  vec_t vec[8];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, got, req);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} === {e.an, e.seg, e.dp, e.tick}) passes++;
      else
        $display("FAIL %s s%0d: got an=%h seg=%h dp=%b tick=%b, required an=%h seg=%h dp=%b tick=%b",
                 e.name, e.sample, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
    end
  endtask

  // Runs one 16-sample frame starting right after a frame_tick sample.
  // load pulse asserted after sample load_at (15 = on the frame boundary);
  // en low after sample en_off_at until after sample en_on_at.
  task automatic do_frame(input string name, input logic [3:0][6:0] eseg,
                          input logic [3:0] edpn, input logic blank,
                          input int load_at, input logic [15:0] lv, input logic [3:0] ldp,
                          input int en_off_at, input int en_on_at);
    exp_t e;
    blank_lz = blank;
    for (int s = 1; s <= 16; s++) begin
      int  d;
      logic off;
      d   = (s - 1) / 4;
      off = (en_off_at > 0) && (s > en_off_at) && (s <= en_on_at);
      e.an     = off ? 4'hF : ~(4'b0001 << d);
      e.seg    = off ? 7'h7F : eseg[d];
      e.dp     = off ? 1'b1 : edpn[d];
      e.tick   = (s == 16);
      e.name   = name;
      e.sample = s;
      sb.push_back(e);
    end
    for (int s = 1; s <= 16; s++) begin
      step();
      load = (s == load_at);
      if (s == load_at) begin
        value = lv;
        dp_in = ldp;
      end
      if (s == en_off_at) en = 1'b0;
      if (s == en_on_at)  en = 1'b1;
    end
  endtask

  initial begin
    logic [3:0][6:0] pseg;
    logic [3:0]      pdpn;
    logic            pblank;

    vec[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vec[1] = '{16'h0005, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111};
    vec[2] = '{16'h0070, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0111};
    vec[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vec[4] = '{16'h89BC, 4'b0101, 1'b1, {7'h00, 7'h10, 7'h03, 7'h46}, 4'b1010};
    vec[5] = '{16'h0F00, 4'b0010, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b1101};
    vec[6] = '{16'h3456, 4'b0000, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1111};
    vec[7] = '{16'hDE67, 4'b1111, 1'b0, {7'h21, 7'h06, 7'h02, 7'h78}, 4'b0000};

    rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0; en = 1'b1; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an",   32'(an),         32'hF);
    check("reset_seg",  32'(seg),        32'h7F);
    check("reset_dp",   32'(dp),         32'h1);
    check("reset_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;

    // Table: each frame loads the next vector on its boundary; the frame
    // after shows it with no extra delay.
    pseg = {4{7'h40}}; pdpn = 4'hF; pblank = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      do_frame($sformatf("vec%0d_prev", i), pseg, pdpn, pblank, 15,
               vec[i].value, vec[i].dp_in, 0, 0);
      pseg = vec[i].seg; pdpn = vec[i].dpn; pblank = vec[i].blank;
    end
    do_frame("vec7_show", pseg, pdpn, pblank, 15, 16'h1111, 4'h0, 0, 0);

    // Tear-free: mid-frame load at digit 1 must not show until next frame
    do_frame("tear_cur", {4{7'h79}}, 4'hF, 1'b0, 5, 16'h2222, 4'h0, 0, 0);
    do_frame("tear_next", {4{7'h24}}, 4'hF, 1'b0, 0, 16'h2222, 4'h0, 0, 0);

    // en low for 10 cycles mid-scan; tick cadence and index continue
    do_frame("en_off", {4{7'h24}}, 4'hF, 1'b0, 0, 16'h2222, 4'h0, 5, 15);
    do_frame("en_resume", {4{7'h24}}, 4'hF, 1'b0, 0, 16'h2222, 4'h0, 0, 0);

    // Async reset with a load pending
    repeat (5) step();
    value = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an",   32'(an),         32'hF);
    check("async_rst_seg",  32'(seg),        32'h7F);
    check("async_rst_dp",   32'(dp),         32'h1);
    check("async_rst_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;
    do_frame("post_rst0", {4{7'h40}}, 4'hF, 1'b0, 0, 16'hFFFF, 4'hF, 0, 0);
    do_frame("post_rst1", {4{7'h40}}, 4'hF, 1'b0, 0, 16'hFFFF, 4'hF, 0, 0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised, time-multiplexed hex display driver for common-anode multi-digit seven-segment displays.
- Holds an NUM_DIGITS-nibble value and scans one digit at a time with a programmable refresh divider.
- Decodes each nibble to hex glyphs (0-F) and drives per-digit decimal points.
- Supports optional leading-zero blanking.
- Uses tear-free double buffering, so a new value appears only at a frame boundary.
- Sits between the datapath (counters, ALU results) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 100000, clk cycles each digit is lit (legal >= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
value  input  4*NUM_DIGITS  hex value; nibble i (bits 4i+3:4i) drives digit i, digit 0 = rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high
load  input  1  one-cycle strobe; captures value and dp_in into the shadow register
en  input  1  display enable; 0 blanks all outputs
blank_lz  input  1  1 = leading-zero blanking on
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  NUM_DIGITS  anode selects, active-low, one-hot-zero
frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async, rst_n=0):
  - div counter = 0, digit index = 0.
  - shadow and display registers = 0, pending = 0.
  - an = all 1, seg = 7'h7F, dp = 1, frame_tick = 0.
- Divider:
  - The div counter is $clog2(REFRESH_DIV) bits wide and counts 0..REFRESH_DIV-1.
  - On the cycle it is at REFRESH_DIV-1, it returns to 0 and the digit index advances mod NUM_DIGITS.
- Frame boundary: the cycle in which the index advances from NUM_DIGITS-1 to 0.
  - frame_tick = 1 on the clock edge following that cycle; it is registered and lasts 1 cycle.
  - If pending=1, display <= shadow and pending <= 0.
- load:
  - Any cycle: shadow <= {value, dp_in}, pending <= 1.
  - load in the same cycle as a frame boundary: display <= the new {value, dp_in} directly (bypass) and pending stays 0.
  - Multiple loads within a frame: the last one wins.
- Output registers, updated every cycle from the current digit index (1-cycle latency from an index change):
  - an = ~(1 << index).
  - seg = glyph(display nibble[index]).
  - dp = ~display_dp[index].
- Glyphs (seg hex, active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (blank_lz=1):
  - Digit i is blanked when all nibbles i..NUM_DIGITS-1 of display are 0 and i != 0. Digit 0 is never blanked.
  - A blanked digit has seg = 7F; its anode is still driven; dp still follows dp_in.
- en=0:
  - an = all 1, seg = 7F, dp = 1 from the next edge.
  - Divider, index, load and frame logic keep running; frame_tick still pulses.
- NUM_DIGITS=1: index is constant 0 and every divider wrap is a frame boundary.
- Reset asserted mid-frame: all state clears immediately; a pending load is discarded.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=4, en=1, blank_lz=0; after reset, load value=16'h12AF, dp_in=4'b0000 at the first boundary -> next frame shows an=E,seg=0E; an=D,seg=08; an=B,seg=24; an=7,seg=79. Each pattern holds 4 cycles, and frame_tick is a 1-cycle pulse every 16 cycles.
2. Tear-free load: display 16'h1111; load 16'h2222 mid-frame at index 1 -> digits 2 and 3 of the current frame still show 79; from the next frame every digit shows 24.
3. Load coincident with frame boundary, value=16'h0005 -> the very next digit-0 slot shows seg=12 with no frame of delay.
4. blank_lz=1, value=16'h0070, dp_in=4'b1000 -> digit 0 = 40; digit 1 = 78; digit 2 = 7F; digit 3 = seg 7F with dp=0. value=16'h0000 -> only digit 0 is lit, showing 40.
5. en dropped for 10 cycles mid-scan -> an=F, seg=7F, dp=1 during that window; frame_tick cadence is unchanged; scan resumes at the correct index.
6. rst_n asserted asynchronously between clk edges with a load pending -> outputs go to reset values immediately. After release, the display shows 0 on digit 0 (seg=40) and the pending value never appears.
